// File: rtl/dsi_pkg.sv
// dsi_pkg: shared DSI data-lane state encoding, sync byte and LP line encodings
package dsi_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_LP01,
    ST_LP00,
    ST_ZERO,
    ST_SYNC,
    ST_DATA,
    ST_LAST,
    ST_TRAIL,
    ST_EXIT,
    ST_DRAIN
  } state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;
endpackage

// File: rtl/data_lane_ctrl.sv
// data_lane_ctrl: byte-clock sequencer for one DSI data lane (LP entry, HS-zero, sync, payload, trail, LP exit)
//   byte_clk/byte_rst : byte clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready : packet byte stream in
//   hs_req/hs_rdy/clk_idle : handshake with the clock lane
//   lp_p/lp_n : LP line levels; hs_data/hs_hi_z : byte and tri-state to the HS serializer
//   underrun : one-cycle pulse when the stream stalls mid-packet
module data_lane_ctrl
  import dsi_pkg::*;
#(
  parameter int ZERO_CYC  = 6,
  parameter int TRAIL_CYC = 4,
  parameter int EXIT_CYC  = 4
) (
  input  logic       byte_clk,
  input  logic       byte_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       hs_req,
  input  logic       hs_rdy,
  input  logic       clk_idle,
  output logic       lp_p,
  output logic       lp_n,
  output logic [7:0] hs_data,
  output logic       hs_hi_z,
  output logic       underrun
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [1:0] lp;
  logic drain;
  logic ur;
  assign in_ready = state inside {ST_SYNC, ST_DATA, ST_DRAIN};
  assign ur = (state inside {ST_SYNC, ST_DATA}) && !in_valid;
  assign lp_p = lp[1];
  assign lp_n = lp[0];
  // ST_LAST is the cycle that shows the final payload byte after it was accepted
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = in_valid && clk_idle ? ST_REQ : ST_IDLE;
      ST_REQ:   nxt = hs_rdy ? ST_LP01 : ST_REQ;
      ST_LP01:  nxt = ST_LP00;
      ST_LP00:  nxt = ST_ZERO;
      ST_ZERO:  nxt = cnt == 4'(ZERO_CYC - 1) ? ST_SYNC : ST_ZERO;
      ST_SYNC,
      ST_DATA:  nxt = !in_valid ? ST_TRAIL : in_last ? ST_LAST : ST_DATA;
      ST_LAST:  nxt = ST_TRAIL;
      ST_TRAIL: nxt = cnt == 4'(TRAIL_CYC - 1) ? ST_EXIT : ST_TRAIL;
      ST_EXIT:  nxt = !hs_req && clk_idle ? (drain ? ST_DRAIN : ST_IDLE) : ST_EXIT;
      ST_DRAIN: nxt = in_valid && in_last ? ST_IDLE : ST_DRAIN;
      default:  nxt = ST_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they belong to;
  // the trail byte is derived from whatever byte is on hs_data when TRAIL is entered
  always_ff @(posedge byte_clk) begin
    if (byte_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lp       <= LP_11;
      hs_hi_z  <= 1'b1;
      hs_req   <= 1'b0;
      hs_data  <= 8'h00;
      underrun <= 1'b0;
      drain    <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= nxt != state ? 4'd0 : state == ST_EXIT && !hs_req ? cnt : cnt + 4'd1;
      lp       <= nxt == ST_LP01 ? LP_01
                : nxt inside {ST_LP00, ST_ZERO, ST_SYNC, ST_DATA, ST_LAST, ST_TRAIL} ? LP_00 : LP_11;
      hs_hi_z  <= !(nxt inside {ST_ZERO, ST_SYNC, ST_DATA, ST_LAST, ST_TRAIL});
      hs_req   <= (nxt inside {ST_REQ, ST_LP01, ST_LP00, ST_ZERO, ST_SYNC, ST_DATA, ST_LAST, ST_TRAIL})
                || (nxt == ST_EXIT && (state != ST_EXIT || (hs_req && cnt != 4'(EXIT_CYC - 1))));
      hs_data  <= nxt == ST_SYNC ? SYNC_BYTE
                : nxt inside {ST_DATA, ST_LAST} ? in_data
                : nxt == ST_TRAIL ? (state == ST_TRAIL ? hs_data : {8{~hs_data[7]}}) : 8'h00;
      underrun <= ur;
      drain    <= ur ? 1'b1 : state == ST_EXIT && nxt != ST_EXIT ? 1'b0 : drain;
    end
  end
endmodule

// File: tb/tb_data_lane_ctrl.sv
// tb_data_lane_ctrl: directed packet vectors plus cycle table for the minimum-parameter instance
module tb_data_lane_ctrl;
  typedef struct {
    int n;
    logic [3:0][7:0] b;
    int gap;
    int tx;
    logic [7:0] trail;
    int ur;
    int rdy;
  } vec_t;
  typedef struct {
    logic v;
    logic l;
    logic [7:0] d;
    logic [1:0] lp;
    logic hz;
    logic rq;
    logic [7:0] hd;
    logic rdy;
  } cyc_t;
  logic byte_clk = 0;
  logic byte_rst = 1;
  always #5 byte_clk = ~byte_clk;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_last = 0, hs_rdy = 0, clk_idle = 1;
  logic in_ready, hs_req, lp_p, lp_n, hs_hi_z, underrun;
  logic [7:0] hs_data;
  logic [7:0] in_data1 = 0;
  logic in_valid1 = 0, in_last1 = 0, hs_rdy1 = 1, clk_idle1 = 1;
  logic in_ready1, hs_req1, lp_p1, lp_n1, hs_hi_z1, underrun1;
  logic [7:0] hs_data1;
  data_lane_ctrl dut (
    .byte_clk(byte_clk), .byte_rst(byte_rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .hs_req(hs_req), .hs_rdy(hs_rdy),
    .clk_idle(clk_idle), .lp_p(lp_p), .lp_n(lp_n), .hs_data(hs_data),
    .hs_hi_z(hs_hi_z), .underrun(underrun)
  );
  data_lane_ctrl #(.ZERO_CYC(1), .TRAIL_CYC(1), .EXIT_CYC(1)) dut1 (
    .byte_clk(byte_clk), .byte_rst(byte_rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_last(in_last1), .in_ready(in_ready1), .hs_req(hs_req1), .hs_rdy(hs_rdy1),
    .clk_idle(clk_idle1), .lp_p(lp_p1), .lp_n(lp_n1), .hs_data(hs_data1),
    .hs_hi_z(hs_hi_z1), .underrun(underrun1)
  );
  int checks = 0, failures = 0;
  logic busy = 0, d1 = 0, d2 = 0;
  logic [7:0] hs_q[$];
  logic [1:0] lp_q[$];
  logic [1:0] last_lp = 2'b11;
  logic hs_seen = 0;
  int ur_cnt = 0, rdy_cnt = 0, exit_cnt = 0;
  vec_t v[6];
  cyc_t c[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // clock lane: hs_rdy two cycles after hs_req, back in LP11 two cycles after release
  initial forever begin
    @(negedge byte_clk);
    d2 = d1;
    d1 = hs_req;
    hs_rdy = d2;
    clk_idle = !hs_req && !d2 && !busy;
  end
  initial forever begin
    @(negedge byte_clk);
    if (!hs_hi_z) begin
      hs_q.push_back(hs_data);
      hs_seen = 1;
    end
    if (underrun) ur_cnt++;
    if (in_ready && !hs_hi_z) rdy_cnt++;
    if (hs_seen && hs_req && {lp_p, lp_n} == 2'b11) exit_cnt++;
    if ({lp_p, lp_n} != last_lp) begin
      lp_q.push_back({lp_p, lp_n});
      last_lp = {lp_p, lp_n};
    end
  end
  task automatic clear();
    hs_q.delete();
    lp_q.delete();
    last_lp = {lp_p, lp_n};
    hs_seen = 0;
    ur_cnt = 0;
    rdy_cnt = 0;
    exit_cnt = 0;
  endtask
  task automatic send(input vec_t x);
    int i = 0;
    int t = 0;
    logic acc;
    logic gapped = 0;
    in_data = x.b[0];
    in_last = (x.n == 1);
    in_valid = 1;
    while (i < x.n && t < 400) begin
      @(negedge byte_clk);
      t++;
      if (in_ready && i == x.gap && !gapped) begin
        in_valid = 0;
        gapped = 1;
      end
      acc = in_ready && in_valid;
      @(posedge byte_clk);
      #1;
      if (acc) begin
        i++;
        if (i < x.n) begin
          in_data = x.b[i];
          in_last = (i == x.n - 1);
        end
      end else in_valid = 1;
    end
    in_valid = 0;
    in_last = 0;
    if (i < x.n) chk("send_timeout", i, x.n);
  endtask
  task automatic run_vec(input vec_t x, input string tag);
    int t = 0;
    int len;
    @(posedge byte_clk);
    #1;
    clear();
    send(x);
    while (!(exit_cnt > 0 && !hs_req) && t < 200) begin
      @(negedge byte_clk);
      t++;
    end
    len = 11 + x.tx;
    chk({tag, " hs_len"}, hs_q.size(), len);
    for (int k = 0; k < len && k < hs_q.size(); k++) begin
      logic [7:0] e;
      e = k < 6 ? 8'h00 : k == 6 ? 8'hB8 : k < 7 + x.tx ? x.b[k-7] : x.trail;
      chk($sformatf("%s hs[%0d]", tag, k), hs_q[k], e);
    end
    chk({tag, " lp_changes"}, lp_q.size(), 3);
    if (lp_q.size() == 3) chk({tag, " lp_seq"}, {lp_q[0], lp_q[1], lp_q[2]}, 6'b01_00_11);
    chk({tag, " underrun"}, ur_cnt, x.ur);
    chk({tag, " ready_cyc"}, rdy_cnt, x.rdy);
    chk({tag, " exit_req_cyc"}, exit_cnt, 4);
  endtask
  initial begin
    int bad;
    int t;
    v[0] = '{3, 32'h00832211, -1, 3, 8'h00, 0, 3};
    v[1] = '{1, 32'h00000005, -1, 1, 8'hFF, 0, 1};
    v[2] = '{4, 32'h99776241, 2, 2, 8'hFF, 1, 3};
    v[3] = '{2, 32'h00003CC3, -1, 2, 8'hFF, 0, 2};
    v[4] = '{2, 32'h0000BBAA, 0, 0, 8'h00, 1, 1};
    v[5] = '{2, 32'h0000807F, -1, 2, 8'h00, 0, 2};
    c[0]  = '{1, 1, 8'h05, 2'b11, 1, 0, 8'h00, 0};
    c[1]  = '{1, 1, 8'h05, 2'b11, 1, 1, 8'h00, 0};
    c[2]  = '{1, 1, 8'h05, 2'b01, 1, 1, 8'h00, 0};
    c[3]  = '{1, 1, 8'h05, 2'b00, 1, 1, 8'h00, 0};
    c[4]  = '{1, 1, 8'h05, 2'b00, 0, 1, 8'h00, 0};
    c[5]  = '{1, 1, 8'h05, 2'b00, 0, 1, 8'hB8, 1};
    c[6]  = '{0, 0, 8'h00, 2'b00, 0, 1, 8'h05, 0};
    c[7]  = '{0, 0, 8'h00, 2'b00, 0, 1, 8'hFF, 0};
    c[8]  = '{0, 0, 8'h00, 2'b11, 1, 1, 8'h00, 0};
    c[9]  = '{0, 0, 8'h00, 2'b11, 1, 0, 8'h00, 0};
    c[10] = '{0, 0, 8'h00, 2'b11, 1, 0, 8'h00, 0};
    repeat (3) @(negedge byte_clk);
    chk("rst lp", {lp_p, lp_n}, 2'b11);
    chk("rst hi_z", hs_hi_z, 1);
    chk("rst hs_req", hs_req, 0);
    chk("rst hs_data", hs_data, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst underrun", underrun, 0);
    @(posedge byte_clk);
    #1;
    byte_rst = 0;
    run_vec(v[0], "pkt3");
    run_vec(v[1], "pkt1");
    run_vec(v[2], "underrun");
    run_vec(v[3], "after_drain");
    busy = 1;
    in_data = 8'h7F;
    in_valid = 1;
    bad = 0;
    repeat (10) begin
      @(negedge byte_clk);
      if (hs_req || {lp_p, lp_n} != 2'b11 || !hs_hi_z) bad++;
    end
    chk("clk_busy_hold", bad, 0);
    busy = 0;
    run_vec(v[5], "after_busy");
    run_vec(v[4], "no_first");
    @(posedge byte_clk);
    #1;
    clear();
    in_data = 8'h5A;
    in_last = 0;
    in_valid = 1;
    t = 0;
    do begin
      @(negedge byte_clk);
      t++;
    end while (!(in_ready && !hs_hi_z && hs_data == 8'h5A) && t < 200);
    if (t >= 200) chk("mid_rst reach_data", hs_data, 8'h5A);
    byte_rst = 1;
    @(negedge byte_clk);
    chk("mid_rst lp", {lp_p, lp_n}, 2'b11);
    chk("mid_rst hi_z", hs_hi_z, 1);
    chk("mid_rst hs_req", hs_req, 0);
    chk("mid_rst in_ready", in_ready, 0);
    chk("mid_rst hs_data", hs_data, 0);
    @(posedge byte_clk);
    #1;
    byte_rst = 0;
    in_valid = 0;
    run_vec(v[0], "post_rst");
    for (int k = 0; k < 11; k++) begin
      @(negedge byte_clk);
      chk($sformatf("min[%0d] lp", k), {lp_p1, lp_n1}, c[k].lp);
      chk($sformatf("min[%0d] hi_z", k), hs_hi_z1, c[k].hz);
      chk($sformatf("min[%0d] hs_req", k), hs_req1, c[k].rq);
      chk($sformatf("min[%0d] hs_data", k), hs_data1, c[k].hd);
      chk($sformatf("min[%0d] in_ready", k), in_ready1, c[k].rdy);
      in_valid1 = c[k].v;
      in_last1 = c[k].l;
      in_data1 = c[k].d;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
